ft2232h_rx_ctrl: RTL

FPGA-side read controller for the FT2232H synchronous 245 FIFO receive path. It drives the chip's active-low OE#/RD# strobes and captures bytes from the chip's 8-bit data bus while RXF# reports data available. Captured bytes go into a small internal buffer and are presented downstream as a valid/ready byte stream for the host-command parser. It sits directly downstream of the FT2232H RX port (data, rxf, rd, oe, clk).

---
 rtl/ft2232h_pkg.sv | 30 +++
 rtl/ft2232h_rx_ctrl_if.sv | 31 +++
 rtl/ft2232h_byte_fifo.sv | 61 ++++++
 rtl/ft2232h_rx_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/ft2232h_pkg.sv
// ============================================================================
// Module      : ft2232h_pkg
// Description : Shared types and constants for the FT2232H sync-245 FIFO
//               RX/TX controllers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ft2232h_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OE_WAIT = 2'd1,
    ST_READ    = 2'd2
  } rx_state_t;

  // Active-low strobe levels on the chip side.
  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  localparam int DEFAULT_FIFO_DEPTH = 8;

  // Pointer width with one extra wrap bit for full/empty disambiguation.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ft2232h_rx_ctrl_if.sv
// ============================================================================
// Module      : ft2232h_rx_ctrl_if
// Description : FT2232H RX chip bus plus downstream valid/ready byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ft2232h_rx_ctrl_if;

  logic       rxf_i;
  logic [7:0] data_i;
  logic       oe_o;
  logic       rd_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;

  // master: the read controller; slave: chip and stream consumer side.
  modport master (
    input  rxf_i, data_i, m_ready_i,
    output oe_o, rd_o, m_data_o, m_valid_o
  );

  modport slave (
    output rxf_i, data_i, m_ready_i,
    input  oe_o, rd_o, m_data_o, m_valid_o
  );

endinterface

`default_nettype wire

// File: rtl/ft2232h_byte_fifo.sv
// ============================================================================
// Module      : ft2232h_byte_fifo
// Description : Synchronous first-word-fall-through byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft2232h_byte_fifo
  import ft2232h_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  wire logic                        clk_i,
  input  wire logic                        rst_n_i,
  input  wire logic                        push,
  input  wire logic                        pop,
  input  wire logic [7:0]                  din,
  output logic      [7:0]                  dout,
  output logic                             empty,
  output logic                             full,
  output logic      [$clog2(FIFO_DEPTH):0] count
);

  localparam int C_AW = $clog2(FIFO_DEPTH);
  localparam int C_PW = fifo_ptr_w(FIFO_DEPTH);

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [C_PW-1:0] r_wptr;
  logic [C_PW-1:0] r_rptr;
  logic            w_pop_ok;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[C_AW] != r_rptr[C_AW]) &&
                 (r_wptr[C_AW-1:0] == r_rptr[C_AW-1:0]);
  assign count = r_wptr - r_rptr;
  assign dout  = r_mem[r_rptr[C_AW-1:0]];

  assign w_pop_ok = pop && !empty;

  // Storage is reset so the head byte reads as zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push) begin
        r_mem[r_wptr[C_AW-1:0]] <= din;
        r_wptr                  <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ft2232h_rx_ctrl.sv
// ============================================================================
// Module      : ft2232h_rx_ctrl
// Description : FT2232H sync-245 FIFO read controller feeding a byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft2232h_rx_ctrl
  import ft2232h_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_W      = 32
) (
  input  wire logic             clk_i,
  input  wire logic             rst_n_i,
  input  wire logic             en_i,
  ft2232h_rx_ctrl_if.master     rx_if,
  output logic      [CNT_W-1:0] rx_count_o,
  output logic                  busy_o
);

  localparam int               C_AW       = $clog2(FIFO_DEPTH);
  localparam logic [C_AW:0]    C_ROOM_MAX = (C_AW + 1)'(FIFO_DEPTH - 2);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic             r_oe;
  logic             r_rd;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;

  logic             w_room;
  logic             w_capture;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [C_AW:0]    w_fifo_count;
  logic [7:0]       w_fifo_dout;

  // Leaving room for one more byte covers the capture that still lands on
  // the edge where the FSM decides to stop.
  assign w_room    = (w_fifo_count <= C_ROOM_MAX);
  assign w_capture = (r_state == ST_READ) && (r_rd == LO) && (rx_if.rxf_i == LO);
  assign w_push    = w_capture && !w_full;
  assign w_pop     = !w_empty && rx_if.m_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en_i && (rx_if.rxf_i == LO) && w_room) begin
          w_state_nxt = ST_OE_WAIT;
        end
      end
      ST_OE_WAIT: begin
        if (en_i && (rx_if.rxf_i == LO) && w_room) begin
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if ((rx_if.rxf_i == HI) || !w_room || !en_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_oe    <= HI;
      r_rd    <= HI;
      r_busy  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_oe    <= (w_state_nxt == ST_IDLE) ? HI : LO;
      r_rd    <= (w_state_nxt == ST_READ) ? LO : HI;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_push) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  ft2232h_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (w_push),
    .pop     (w_pop),
    .din     (rx_if.data_i),
    .dout    (w_fifo_dout),
    .empty   (w_empty),
    .full    (w_full),
    .count   (w_fifo_count)
  );

  assign rx_if.oe_o      = r_oe;
  assign rx_if.rd_o      = r_rd;
  assign rx_if.m_data_o  = w_fifo_dout;
  assign rx_if.m_valid_o = !w_empty;
  assign rx_count_o      = r_count;
  assign busy_o          = r_busy;

endmodule

`default_nettype wire
